// File: rtl/ble_cmd_wrapper.sv
// BLE UART command wrapper: assembles two rx bytes into a 16-bit command
// and converts send_resp requests into single-byte acknowledge transmissions.
`timescale 1ns/1ps
module ble_cmd_wrapper #(
  parameter logic [7:0]  RESP     = 8'hA5,
  parameter logic [23:0] TIMEOUT  = 24'd5_000_000,
  parameter int          FAST_SIM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic        trmt,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        cmd_ovr
);

  localparam logic [23:0] TMO_EFF = (FAST_SIM != 0) ? (TIMEOUT >> 10) : TIMEOUT;

  typedef enum logic {HIGH, LOW} state_t;

  state_t      state_q, state_d;
  logic [7:0]  high_q, high_d;
  logic [23:0] tmr_q, tmr_d;
  logic [15:0] cmd_q, cmd_d;
  logic        cmd_rdy_q, cmd_rdy_d;
  logic        cmd_ovr_q, cmd_ovr_d;
  logic        trmt_q, trmt_d;
  logic        tx_busy_q, tx_busy_d;
  logic        resp_pend_q, resp_pend_d;
  logic        cap_lo;
  logic        busy;

  // Every rx_rdy cycle captures a byte in either state, so the consume pulse
  // tracks rx_rdy directly; gated so nothing is consumed while in reset.
  assign clr_rx_rdy = rx_rdy & rst_n;

  always_comb begin
    state_d = state_q;
    high_d  = high_q;
    tmr_d   = tmr_q;
    cap_lo  = 1'b0;
    unique case (state_q)
      HIGH: begin
        if (rx_rdy) begin
          high_d  = rx_data;
          tmr_d   = TMO_EFF;
          state_d = LOW;
        end
      end
      LOW: begin
        if (rx_rdy) begin
          cap_lo  = 1'b1;
          state_d = HIGH;
        end else if (tmr_q == 24'd0) begin
          state_d = HIGH;
        end else begin
          tmr_d = tmr_q - 24'd1;
        end
      end
    endcase
  end

  always_comb begin
    cmd_d     = cap_lo ? {high_q, rx_data} : cmd_q;
    cmd_rdy_d = cap_lo ? 1'b1 : (clr_cmd_rdy ? 1'b0 : cmd_rdy_q);
    cmd_ovr_d = cap_lo & cmd_rdy_q & ~clr_cmd_rdy;
  end

  // trmt_q counts as busy so a request in the issue cycle is queued, not doubled.
  assign busy = tx_busy_q | trmt_q;

  always_comb begin
    trmt_d      = 1'b0;
    resp_pend_d = resp_pend_q;
    tx_busy_d   = tx_busy_q;
    if (trmt_q) begin
      tx_busy_d = 1'b1;
    end else if (tx_done) begin
      tx_busy_d = 1'b0;
    end
    if (tx_done && busy) begin
      trmt_d      = resp_pend_q | send_resp;
      resp_pend_d = 1'b0;
    end else if (send_resp) begin
      if (busy) begin
        resp_pend_d = 1'b1;
      end else if (!resp_pend_q) begin
        trmt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HIGH;
      high_q      <= '0;
      tmr_q       <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      cmd_ovr_q   <= 1'b0;
      trmt_q      <= 1'b0;
      tx_busy_q   <= 1'b0;
      resp_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      high_q      <= high_d;
      tmr_q       <= tmr_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      cmd_ovr_q   <= cmd_ovr_d;
      trmt_q      <= trmt_d;
      tx_busy_q   <= tx_busy_d;
      resp_pend_q <= resp_pend_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign cmd_ovr = cmd_ovr_q;
  assign trmt    = trmt_q;
  assign tx_data = RESP;

endmodule

// File: tb/tb_ble_cmd_wrapper.sv
// Directed bench for ble_cmd_wrapper: expected commands are queued as bytes
// are driven and popped when cmd_rdy presents the assembled command.
`timescale 1ns/1ps
module tb_ble_cmd_wrapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_rdy;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        cmd_ovr;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int ovr_cnt = 0;
  int trmt_cnt = 0;
  logic [15:0] exp_q[$];

  ble_cmd_wrapper #(
    .RESP(8'hA5),
    .TIMEOUT(24'd10240),
    .FAST_SIM(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_rdy(rx_rdy),
    .clr_rx_rdy(clr_rx_rdy), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .trmt(trmt),
    .tx_data(tx_data), .tx_done(tx_done), .cmd_ovr(cmd_ovr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_rx_rdy) rx_cnt <= rx_cnt + 1;
    if (cmd_ovr)    ovr_cnt <= ovr_cnt + 1;
    if (trmt)       trmt_cnt <= trmt_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    #1;
    chk("clr_rx_rdy_pulse", clr_rx_rdy, 1);
    @(posedge clk);
    #1;
    rx_rdy  = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo);
    exp_q.push_back({hi, lo});
    send_byte(hi);
    tick(2);
    send_byte(lo);
  endtask

  task automatic expect_cmd(input string tag);
    logic [15:0] e;
    int n;
    n = 0;
    while (!cmd_rdy && n < 4) begin
      tick();
      n++;
    end
    chk({tag, "_rdy"}, cmd_rdy, 1);
    e = exp_q.pop_front();
    chk(tag, cmd, e);
  endtask

  task automatic clear_cmd();
    clr_cmd_rdy = 1'b1;
    tick();
    clr_cmd_rdy = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  int r0, o0, t0;

  initial begin
    rst_n = 1'b0; rx_data = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    send_resp = 1'b0; tx_done = 1'b0;
    tick(2);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_trmt", trmt, 0);
    chk("rst_cmd_ovr", cmd_ovr, 0);
    rx_rdy = 1'b1;
    #1;
    chk("rst_clr_rx_rdy", clr_rx_rdy, 0);
    rx_rdy = 1'b0;
    rst_n = 1'b1;
    tick();

    // basic command and handshake
    r0 = rx_cnt;
    send_cmd(8'h41, 8'h23);
    expect_cmd("cmd_4123");
    chk("rx_pulses", rx_cnt - r0, 2);
    clear_cmd();
    chk("cmd_rdy_cleared", cmd_rdy, 0);
    chk("cmd_held", cmd, 16'h4123);

    // low byte on the last cycle before expiry is still accepted
    exp_q.push_back(16'h2077);
    send_byte(8'h20);
    tick(10);
    send_byte(8'h77);
    expect_cmd("cmd_edge");
    clear_cmd();

    // dangling high byte discarded after timeout
    send_byte(8'h20);
    tick(12);
    chk("to_no_cmd", cmd_rdy, 0);
    send_cmd(8'h60, 8'h00);
    expect_cmd("cmd_6000");
    clear_cmd();

    // overrun
    o0 = ovr_cnt;
    send_cmd(8'h20, 8'h00);
    expect_cmd("ovr_first");
    chk("ovr_none_first", cmd_ovr, 0);
    send_cmd(8'h4A, 8'h01);
    chk("ovr_pulse", cmd_ovr, 1);
    expect_cmd("ovr_second");
    tick();
    chk("ovr_one_cycle", cmd_ovr, 0);
    chk("ovr_count", ovr_cnt - o0, 1);
    chk("ovr_rdy_held", cmd_rdy, 1);

    // clear and capture on the same edge: set wins, no overrun
    o0 = ovr_cnt;
    send_byte(8'h55);
    tick(2);
    exp_q.push_back(16'h5566);
    rx_data = 8'h66; rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    chk("set_wins", cmd_rdy, 1);
    expect_cmd("cmd_5566");
    chk("set_wins_no_ovr", ovr_cnt - o0, 0);
    clear_cmd();

    // response path
    t0 = trmt_cnt;
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    chk("trmt_idle", trmt, 1);
    chk("tx_data", tx_data, 8'hA5);
    tick();
    chk("trmt_one_cycle", trmt, 0);
    repeat (3) begin
      send_resp = 1'b1;
      tick();
      send_resp = 1'b0;
      tick();
    end
    chk("no_trmt_busy", trmt_cnt - t0, 1);
    pulse_done();
    chk("trmt_after_done", trmt, 1);
    tick(3);
    chk("one_extra_trmt", trmt_cnt - t0, 2);
    pulse_done();
    tick(2);
    chk("no_trmt_after_last_done", trmt_cnt - t0, 2);

    // send_resp and tx_done together while busy
    send_resp = 1'b1;
    tick();
    send_resp = 1'b0;
    tick(2);
    send_resp = 1'b1; tx_done = 1'b1;
    tick();
    send_resp = 1'b0; tx_done = 1'b0;
    chk("trmt_same_cycle", trmt, 1);
    tick(3);
    chk("same_cycle_count", trmt_cnt - t0, 4);
    pulse_done();

    // reset while waiting for the low byte
    send_byte(8'h41);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_cmd", cmd, 16'h0000);
    chk("midrst_rdy", cmd_rdy, 0);
    send_cmd(8'h12, 8'h34);
    expect_cmd("cmd_1234");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
